// File: rtl/apmu_csr_pkg.sv
// Shared types for the APMU CSR arbiter slice.
//   csr_op_e    : access opcode carried on op_i
//   arb_state_e : arbiter FSM states
//   csr_req_t   : latched request (op, addr, wdata, owner)
//   csr_apply   : computes the post-modification value of a write-type op
// Optional feature macro: APMU_CSR_SHADOW_EN (selects shadowed CSR cells).
package apmu_csr_pkg;

    // The request struct is shared by every instance, so its fields are sized
    // for the largest legal configuration and narrowed inside the top.
    localparam int unsigned OwnerW   = 2;   // up to 4 requesters
    localparam int unsigned AddrMaxW = 8;
    localparam int unsigned DataMaxW = 64;

`ifdef APMU_CSR_SHADOW_EN
    localparam bit ShadowEn = 1'b1;
`else
    localparam bit ShadowEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_SET   = 2'd2,
        OP_CLEAR = 2'd3
    } csr_op_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        csr_op_e               op;
        logic [AddrMaxW-1:0]   addr;
        logic [DataMaxW-1:0]   wdata;
        logic [OwnerW-1:0]     owner;
    } csr_req_t;

    function automatic logic [DataMaxW-1:0] csr_apply(
        input csr_op_e             op,
        input logic [DataMaxW-1:0] old_val,
        input logic [DataMaxW-1:0] operand
    );
        logic [DataMaxW-1:0] result;
        case (op)
            OP_WRITE: result = operand;
            OP_SET:   result = old_val | operand;
            OP_CLEAR: result = old_val & ~operand;
            default:  result = old_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/apmu_csr_bank.sv
// Bank of NumRegs CSR cells sharing one write-data bus.
//   wr_data_i  : value written into every enabled cell
//   wr_en_i    : one-hot write enables, one per cell
//   rd_data_o  : all cell values, cell i at [i*Width +: Width]
//   rd_error_o : per-cell shadow integrity error
// Shadowing follows APMU_CSR_SHADOW_EN through apmu_csr_pkg::ShadowEn.
module apmu_csr_bank
    import apmu_csr_pkg::*;
#(
    parameter int unsigned              NumRegs   = 8,
    parameter int unsigned              Width     = 32,
    parameter logic [NumRegs*Width-1:0] ResetVals = '0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [Width-1:0]         wr_data_i,
    input  logic [NumRegs-1:0]       wr_en_i,
    output logic [NumRegs*Width-1:0] rd_data_o,
    output logic [NumRegs-1:0]       rd_error_o
);

    generate
        for (genvar gi = 0; gi < NumRegs; gi++) begin : g_cell
            apmu_ibex_csr #(
                .Width      (Width),
                .ShadowCopy (ShadowEn),
                .ResetValue (ResetVals[gi*Width +: Width])
            ) u_cell (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .wr_data_i  (wr_data_i),
                .wr_en_i    (wr_en_i[gi]),
                .rd_data_o  (rd_data_o[gi*Width +: Width]),
                .rd_error_o (rd_error_o[gi])
            );
        end
    endgenerate

endmodule

// File: rtl/apmu_ibex_csr.sv
// Single CSR storage cell with optional inverted shadow copy.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wr_data_i     : value stored when wr_en_i is high
//   rd_data_o     : current register value
//   rd_error_o    : shadow copy disagrees with the main copy
module apmu_ibex_csr #(
    parameter int unsigned      Width      = 32,
    parameter bit               ShadowCopy = 1'b0,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] wr_data_i,
    input  logic             wr_en_i,
    output logic [Width-1:0] rd_data_o,
    output logic             rd_error_o
);

    logic [Width-1:0] rdata_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_reg <= ResetValue;
        end else if (wr_en_i) begin
            rdata_reg <= wr_data_i;
        end
    end

    assign rd_data_o = rdata_reg;

    generate
        if (ShadowCopy) begin : g_shadow
            // Shadow holds the complement so a stuck-at fault on a shared
            // net cannot make both copies agree.
            logic [Width-1:0] shadow_reg;
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    shadow_reg <= ~ResetValue;
                end else if (wr_en_i) begin
                    shadow_reg <= ~wr_data_i;
                end
            end
            assign rd_error_o = (rdata_reg != ~shadow_reg);
        end else begin : g_no_shadow
            assign rd_error_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apmu_csr_arbiter.sv
// Round-robin arbiter sequencing read/write/set/clear accesses from NumReq
// requesters onto a bank of CSRs. One access per 3 cycles:
// gnt in T, read-modify-write at end of T+1, rvalid in T+2.
//   req_i/op_i/addr_i/wdata_i : per-requester request, held until gnt
//   gnt_o    : one-hot grant pulse       rvalid_o : one-hot response pulse
//   rdata_o  : pre-modification value    err_o    : access error
//   busy_o   : FSM not idle              alert_o  : sticky integrity alert
// Optional feature macro: APMU_CSR_SHADOW_EN (shadowed cells + sticky alert).
module apmu_csr_arbiter
    import apmu_csr_pkg::*;
#(
    parameter int unsigned              NumReq    = 2,
    parameter int unsigned              NumRegs   = 8,
    parameter int unsigned              Width     = 32,
    parameter int unsigned              AddrW     = 4,
    parameter logic [NumRegs*Width-1:0] ResetVals = '0,
    parameter logic [NumRegs-1:0]       RoMask    = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumReq-1:0]       req_i,
    input  logic [NumReq*2-1:0]     op_i,
    input  logic [NumReq*AddrW-1:0] addr_i,
    input  logic [NumReq*Width-1:0] wdata_i,
    output logic [NumReq-1:0]       gnt_o,
    output logic [NumReq-1:0]       rvalid_o,
    output logic [Width-1:0]        rdata_o,
    output logic                    err_o,
    output logic                    busy_o,
    output logic                    alert_o
);

    arb_state_e        state_reg, state_next;
    logic [OwnerW-1:0] ptr_reg, ptr_next;
    csr_req_t          req_reg, req_next;
    logic [Width-1:0]  rdata_reg, rdata_next;
    logic              err_reg, err_next;

    logic [NumRegs*Width-1:0] bank_rdata;
    logic [NumRegs-1:0]       bank_err;
    logic [NumRegs-1:0]       bank_wr_en;
    logic [Width-1:0]         bank_wdata;

    logic [NumRegs-1:0] addr_hit;
    logic               addr_legal, addr_ro, cell_err, is_write, access_err;
    logic [Width-1:0]   old_val;
    logic               found;
    logic [OwnerW-1:0]  pick;

    apmu_csr_bank #(
        .NumRegs   (NumRegs),
        .Width     (Width),
        .ResetVals (ResetVals)
    ) u_bank (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wr_data_i  (bank_wdata),
        .wr_en_i    (bank_wr_en),
        .rd_data_o  (bank_rdata),
        .rd_error_o (bank_err)
    );

    // Decode the latched address; an out-of-range address hits no cell and
    // leaves old_val at zero, which is exactly the value returned for it.
    always_comb begin
        addr_hit   = '0;
        addr_legal = 1'b0;
        addr_ro    = 1'b0;
        cell_err   = 1'b0;
        old_val    = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (32'(req_reg.addr) == i) begin
                addr_hit[i] = 1'b1;
                addr_legal  = 1'b1;
                addr_ro     = RoMask[i];
                cell_err    = bank_err[i];
                old_val     = bank_rdata[i*Width +: Width];
            end
        end
    end

    assign is_write   = (req_reg.op != OP_READ);
    assign access_err = !addr_legal || (is_write && addr_ro) || cell_err;
    assign bank_wdata = Width'(csr_apply(req_reg.op, DataMaxW'(old_val), req_reg.wdata));
    assign bank_wr_en = (state_reg == ARB_EXEC && is_write && !access_err) ? addr_hit : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ARB_IDLE;
            ptr_reg   <= '0;
            req_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            req_reg   <= req_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        req_next   = req_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        found      = 1'b0;
        pick       = '0;
        gnt_o      = '0;

        // Outer loop walks priority order starting at the pointer; the inner
        // loop maps that slot back onto a constant requester index.
        for (int i = 0; i < NumReq; i++) begin
            for (int j = 0; j < NumReq; j++) begin
                if (state_reg == ARB_IDLE && !found && req_i[j] &&
                    ((32'(ptr_reg) + 32'(i)) % NumReq) == 32'(j)) begin
                    found          = 1'b1;
                    pick           = OwnerW'(j);
                    gnt_o[j]       = 1'b1;
                    req_next.op    = csr_op_e'(op_i[j*2 +: 2]);
                    req_next.addr  = AddrMaxW'(addr_i[j*AddrW +: AddrW]);
                    req_next.wdata = DataMaxW'(wdata_i[j*Width +: Width]);
                    req_next.owner = OwnerW'(j);
                end
            end
        end

        case (state_reg)
            ARB_IDLE: begin
                if (found) begin
                    ptr_next   = (32'(pick) == NumReq - 1) ? '0 : pick + OwnerW'(1);
                    state_next = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                rdata_next = old_val;
                err_next   = access_err;
                state_next = ARB_RESP;
            end
            ARB_RESP: begin
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        rvalid_o = '0;
        for (int j = 0; j < NumReq; j++) begin
            rvalid_o[j] = (state_reg == ARB_RESP) && (32'(req_reg.owner) == 32'(j));
        end
    end

    assign rdata_o = (state_reg == ARB_RESP) ? rdata_reg : '0;
    assign err_o   = (state_reg == ARB_RESP) ? err_reg : 1'b0;
    assign busy_o  = (state_reg != ARB_IDLE);

`ifdef APMU_CSR_SHADOW_EN
    // Any cell disagreeing with its shadow raises the alert, addressed or not.
    logic alert_reg;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alert_reg <= 1'b0;
        end else begin
            alert_reg <= alert_reg | (|bank_err);
        end
    end
    assign alert_o = alert_reg;
`else
    assign alert_o = 1'b0;
`endif

endmodule

// File: tb/tb_apmu_csr_arbiter.sv
module tb_apmu_csr_arbiter;

    localparam int NR   = 2;
    localparam int NREG = 8;
    localparam int W    = 32;
    localparam int AW   = 4;
    localparam logic [NREG*W-1:0] RESET_VALS = {
        32'h7777_7777, 32'h6666_6666, 32'h5555_5555, 32'h4444_4444,
        32'h0000_00A5, 32'h2222_2222, 32'h0000_0000, 32'h1111_1111};
    localparam logic [NREG-1:0] RO_MASK = 8'b0010_0000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [NR*2-1:0] op = '0;
    logic [NR*AW-1:0] addr = '0;
    logic [NR*W-1:0] wdata = '0;
    logic [NR-1:0]   gnt, rvalid;
    logic [W-1:0]    rdata;
    logic            err, busy, alert;

    apmu_csr_arbiter #(
        .NumReq(NR), .NumRegs(NREG), .Width(W), .AddrW(AW),
        .ResetVals(RESET_VALS), .RoMask(RO_MASK)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .op_i(op), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .err_o(err), .busy_o(busy), .alert_o(alert)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] model [NREG];

    typedef struct {
        int         r;
        logic [1:0] o;
        int         a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        logic [NREG*W-1:0] rv;
        rv = RESET_VALS;
        for (int i = 0; i < NREG; i++) model[i] = rv[i*W +: W];
    endtask

    // Reference behaviour: illegal address -> error, zero data; write-type op
    // on a read-only register -> error, old data; otherwise old data returned
    // and the register updated according to the op.
    task automatic model_access(input logic [1:0] o, input int a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic e);
        logic [NREG-1:0] ro;
        ro = RO_MASK;
        if (a >= NREG) begin
            rd = '0;
            e  = 1'b1;
        end else begin
            rd = model[a];
            if (o != 2'd0 && ro[a]) begin
                e = 1'b1;
            end else begin
                e = 1'b0;
                case (o)
                    2'd1: model[a] = wd;
                    2'd2: model[a] = model[a] | wd;
                    2'd3: model[a] = model[a] & ~wd;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic run_and_check(input int idx, input int r, input logic [1:0] o, input int a,
                                 input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        int gcyc, rcyc, busy_cnt, lat;
        logic viol;
        logic [31:0] got_rd;
        logic got_err;
        logic [NR-1:0] rvm;
        gcyc = -1; rcyc = -1; busy_cnt = 0; viol = 1'b0;
        got_rd = '0; got_err = 1'b0; rvm = '0;
        req = '0;
        req[r] = 1'b1;
        op[r*2 +: 2]    = o;
        addr[r*AW +: AW] = AW'(a);
        wdata[r*W +: W] = wd;
        for (int c = 0; c < 20 && rcyc < 0; c++) begin
            @(negedge clk);
            if ((gnt & ~req) != '0 || $countones(gnt) > 1) viol = 1'b1;
            if (rvalid == '0 && (rdata != '0 || err)) viol = 1'b1;
            if (busy) busy_cnt++;
            if (gcyc < 0 && gnt[r]) gcyc = c;
            if (rvalid != '0) begin
                rcyc = c; got_rd = rdata; got_err = err; rvm = rvalid;
            end
            @(posedge clk);
            #1;
            if (gcyc >= 0) req[r] = 1'b0;
        end
        req = '0;
        lat = (gcyc >= 0 && rcyc >= 0) ? rcyc - gcyc : 99;
        chk($sformatf("t%0d_rdata", idx), got_rd, exp_rd);
        chk($sformatf("t%0d_err", idx), 32'(got_err), 32'(exp_err));
        chk($sformatf("t%0d_latency", idx), 32'(lat), 32'd2);
        chk($sformatf("t%0d_rvalid_owner", idx), 32'(rvm), 32'(1 << r));
        chk($sformatf("t%0d_busy_cycles", idx), 32'(busy_cnt), 32'd2);
        chk($sformatf("t%0d_protocol", idx), 32'(viol), 32'd0);
        $display("txn %0d: req%0d op=%0d addr=%0d wdata=%h -> rdata=%h err=%0b lat=%0d",
                 idx, r, o, a, wd, got_rd, got_err, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_rd;
        logic exp_err;
        logic got, rv_seen, bad;
        int rv_total;
        logic [NR-1:0] last;
        logic [NR-1:0] grants [$];
        logic [1:0] ro_op;
        int ra, rr;
        logic [31:0] rwd;

        tbl[0]  = '{0, 2'd0, 3,  32'h0000_0000, 32'h0000_00A5, 1'b0};
        tbl[1]  = '{0, 2'd1, 1,  32'hFFFF_0000, 32'h0000_0000, 1'b0};
        tbl[2]  = '{1, 2'd2, 1,  32'h0000_00FF, 32'hFFFF_0000, 1'b0};
        tbl[3]  = '{0, 2'd3, 1,  32'h0F00_0000, 32'hFFFF_00FF, 1'b0};
        tbl[4]  = '{1, 2'd0, 1,  32'h0000_0000, 32'hF0FF_00FF, 1'b0};
        tbl[5]  = '{0, 2'd0, 12, 32'h0000_0000, 32'h0000_0000, 1'b1};
        tbl[6]  = '{1, 2'd1, 12, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
        tbl[7]  = '{0, 2'd1, 5,  32'h1234_5678, 32'h5555_5555, 1'b1};
        tbl[8]  = '{1, 2'd0, 5,  32'h0000_0000, 32'h5555_5555, 1'b0};
        tbl[9]  = '{0, 2'd2, 6,  32'h0000_0000, 32'h6666_6666, 1'b0};
        tbl[10] = '{1, 2'd3, 6,  32'h0000_0000, 32'h6666_6666, 1'b0};
        tbl[11] = '{0, 2'd0, 6,  32'h0000_0000, 32'h6666_6666, 1'b0};
        tbl[12] = '{1, 2'd0, 4,  32'h0000_0000, 32'h4444_4444, 1'b0};

        model_reset();

        // Outputs while held in reset and right after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 32'({gnt, rvalid, err, busy, alert}), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ctrl", 32'({gnt, rvalid, err, busy, alert}), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            run_and_check(i, tbl[i].r, tbl[i].o, tbl[i].a, tbl[i].wd, tbl[i].exp_rd, tbl[i].exp_err);
        end

        // Reset while a WRITE from requester 0 is in EXEC.
        req = '0;
        req[0] = 1'b1;
        op[1:0] = 2'd1;
        addr[AW-1:0] = AW'(1);
        wdata[W-1:0] = 32'hCAFE_F00D;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (gnt[0]) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("abort_gnt_seen", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        req = '0;
        rst_n = 1'b0;
        rv_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rvalid != '0) rv_seen = 1'b1;
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rvalid != '0) rv_seen = 1'b1;
        end
        chk("abort_no_rvalid", 32'(rv_seen), 32'd0);
        model_reset();
        @(posedge clk);
        #1;

        // Both requesters continuously: grants alternate starting at 0.
        req = '1;
        op = '0;
        addr = '0;
        last = '0;
        bad = 1'b0;
        rv_total = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                grants.push_back(gnt);
                last = gnt;
            end
            if (rvalid != '0) begin
                rv_total++;
                if (rvalid !== last || rdata !== 32'h1111_1111) bad = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req = '0;
        for (int i = 0; i < 4; i++) begin
            logic [NR-1:0] g;
            g = (i < grants.size()) ? grants[i] : '0;
            chk($sformatf("alt_gnt_%0d", i), 32'(g), (i % 2 == 0) ? 32'd1 : 32'd2);
            $display("alt grant %0d: %b", i, g);
        end
        chk("alt_rvalid_owner", 32'(bad), 32'd0);
        chk("alt_rvalid_count", 32'(rv_total), 32'd5);
        repeat (3) @(posedge clk);
        #1;

        // The aborted write must not have landed.
        model_access(2'd0, 1, 32'd0, exp_rd, exp_err);
        run_and_check(100, 0, 2'd0, 1, 32'd0, exp_rd, exp_err);

        // Randomized accesses against the reference model.
        for (int i = 0; i < 40; i++) begin
            rr    = int'($urandom_range(0, NR - 1));
            ro_op = 2'($urandom_range(0, 3));
            ra    = int'($urandom_range(0, 15));
            rwd   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            model_access(ro_op, ra, rwd, exp_rd, exp_err);
            run_and_check(200 + i, rr, ro_op, ra, rwd, exp_rd, exp_err);
        end

`ifdef APMU_CSR_SHADOW_EN
        // Fresh reset so cell 2 holds a known value, then corrupt its shadow.
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        force dut.u_bank.g_cell[2].u_cell.g_shadow.shadow_reg = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("alert_set", 32'(alert), 32'd1);
        @(posedge clk);
        #1;
        run_and_check(300, 0, 2'd0, 2, 32'd0, 32'h2222_2222, 1'b1);
        run_and_check(301, 1, 2'd0, 0, 32'd0, 32'h1111_1111, 1'b0);
        run_and_check(302, 0, 2'd1, 2, 32'h0000_ABCD, 32'h2222_2222, 1'b1);
        run_and_check(303, 1, 2'd0, 3, 32'd0, 32'h0000_00A5, 1'b0);
        @(negedge clk);
        chk("alert_sticky", 32'(alert), 32'd1);
        release dut.u_bank.g_cell[2].u_cell.g_shadow.shadow_reg;
`else
        @(negedge clk);
        chk("alert_tied_low", 32'(alert), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apmu_csr_arbiter.md
Name: apmu_csr_arbiter

Overview:
Sequences and shares a bank of APMU control/status registers between NumReq requesters, such as the core CSR port and a debug/config port.
- Storage is one apmu_ibex_csr cell per register.
- Every requester uses the same handshake: req/gnt in, then a single-cycle rvalid response.
- Supported ops: read, write, set-bits and clear-bits. Write-type ops are atomic read-modify-write and return the pre-modification value.
- Arbitration is round-robin. Shadow-copy integrity errors are reported per access and as a sticky alert.

Parameters:
NumReq, 2, number of requesters (2..4)
NumRegs, 8, number of CSRs in bank (1..16)
Width, 32, CSR data width
AddrW, 4, address width; addresses >= NumRegs are illegal
ResetVals, '0, packed NumRegs*Width reset values, passed to each cell's ResetValue
RoMask, '0, NumRegs-bit mask; bit set = register read-only

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_i  in  NumReq  request, held until gnt
op_i  in  NumReq*2  0=READ 1=WRITE 2=SET 3=CLEAR
addr_i  in  NumReq*AddrW  register index
wdata_i  in  NumReq*Width  write/set/clear operand
gnt_o  out  NumReq  one-hot grant pulse
rvalid_o  out  NumReq  one-hot response pulse
rdata_o  out  Width  old register value (valid with rvalid)
err_o  out  1  access error (valid with rvalid)
busy_o  out  1  FSM not IDLE
alert_o  out  1  sticky integrity alert

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE; round-robin pointer = 0.
  - Cells hold ResetVals.
  - A reset mid-transaction aborts it: no write and no rvalid.
- FSM states and transitions:
  - IDLE: if any req_i, pick the first requester at or after the pointer (wrapping). Pulse gnt_o for it in the same cycle. Latch op/addr/wdata/owner, then go to EXEC. The pointer becomes owner+1 mod NumReq.
  - EXEC: old = cell[addr].
    - new = wdata for WRITE, old|wdata for SET, old&~wdata for CLEAR.
    - Error if addr >= NumRegs, or a write-type op targets an RoMask register.
    - If no error and op != READ, pulse wr_en for that cell only.
    - Register rdata = old (0 if addr illegal) and the error flag. Go to RESP.
  - RESP: rvalid_o[owner]=1 for one cycle, together with rdata_o/err_o. Go to IDLE.
- Timing:
  - Latency: gnt in cycle T, write takes effect at end of T+1, rvalid in T+2.
  - Max throughput: one access per 3 cycles.
  - gnt_o is 0 outside IDLE; requests are simply held.
- Boundary cases:
  - A requester deasserting req_i before gnt: allowed, nothing happens.
  - gnt_o is never asserted for a requester with req_i=0.
  - SET/CLEAR with wdata=0: still performs the write (same value), no error.
- Data outputs: rdata_o and err_o are 0 when rvalid_o is 0.

Optional Feature:
APMU_CSR_SHADOW_EN
- Defined:
  - Cells are instantiated with ShadowCopy=1.
  - In EXEC, if the addressed cell's rd_error_o=1: err_o is set and the write is suppressed.
  - alert_o sets on any cell rd_error_o, whether or not it is addressed, and stays 1 until reset.
- Undefined: ShadowCopy=0 and alert_o is tied to 0.

Decomposition:
- Package apmu_csr_pkg holds:
  - csr_op_e (READ/WRITE/SET/CLEAR);
  - the arb_state_e enum (IDLE/EXEC/RESP);
  - a request struct (op, addr, wdata, owner).
- Sub-module apmu_csr_bank wraps the NumRegs cells. It exposes:
  - a read-all data vector;
  - one-hot write enables;
  - an error vector.
- Arbitration and FSM stay in the top.

Test Plan:
- Reset, then requester 0 READ addr 3 with ResetVals[3]=32'hA5 -> gnt_o=01 in cycle 0, rvalid_o=01 in cycle 2, rdata_o=32'hA5, err_o=0.
- WRITE 32'hFFFF_0000 to addr 1, then SET 32'h0000_00FF, then CLEAR 32'h0F00_0000, then READ:
  - rdata values returned are 0, FFFF0000, FFFF00FF, F0FF00FF;
  - busy_o is high for exactly 2 cycles per access.
- Both requesters request continuously:
  - grants alternate 01,10,01,10;
  - each rvalid goes to the granted owner.
- Illegal accesses:
  - addr=12 with NumRegs=8 -> err_o=1, rdata_o=0, no cell changes.
  - WRITE to an RoMask register -> err_o=1, value unchanged.
- rst_ni asserted during EXEC of a WRITE -> no rvalid, register equals ResetVals, pointer=0, first grant after reset goes to requester 0.
- With APMU_CSR_SHADOW_EN, force the shadow of cell 2 to mismatch:
  - READ addr 2 -> err_o=1;
  - alert_o=1 and stays 1 after later good accesses.
